// File: rtl/prog_clk_divider.sv
// Programmable clock divider with glitch-free reconfiguration.
//
// A phase counter runs from 0 to div_r-1 on src_clk; clk_out is high while the
// counter (as seen one cycle earlier) is below high_r. New ratios are captured
// into a shadow register on load and only become active at a period boundary,
// so no runt or shortened period is ever produced.
//
// Optional feature: define PROG_CLK_HALF_CYCLE_EN to add a negedge register
// that lets half_en stretch the high time by half a src_clk cycle. Without the
// macro half_en is ignored and clk_out is purely posedge-registered.
//
// Ports:
//   src_clk    - single source clock
//   reset      - synchronous active-high reset
//   enable     - 1 runs the divider, 0 holds it stopped with count at 0
//   load       - single-cycle request to capture div_ratio / high_cnt
//   div_ratio  - requested period in src_clk cycles (>= 2)
//   high_cnt   - requested high time in src_clk cycles (1 .. div_ratio-1)
//   half_en    - add half a src_clk cycle to the high time (macro builds only)
//   clk_out    - divided clock
//   tick       - one-cycle pulse coinciding with each clk_out rising edge
//   count      - current phase counter
//   busy       - a validated configuration is waiting for the next boundary
//   err        - one-cycle pulse when a load is rejected
module prog_clk_divider #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DIV_DEFAULT  = 5,
  parameter int unsigned HIGH_DEFAULT = 2
) (
  input  logic             src_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] div_ratio,
  input  logic [WIDTH-1:0] high_cnt,
  input  logic             half_en,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             err
);

  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] high_r;
  logic [WIDTH-1:0] shd_div;
  logic [WIDTH-1:0] shd_high;
  logic             clk_pos;

  logic load_ok_c;
  logic wrap_c;
  logic apply_c;

  // Load qualification: period of at least 2 and a high time strictly inside it.
  assign load_ok_c = (div_ratio >= WIDTH'(2)) && (high_cnt >= WIDTH'(1)) &&
                     (high_cnt < div_ratio);

  // div_r is never below 2, so div_r-1 cannot underflow.
  assign wrap_c  = enable && (count == (div_r - WIDTH'(1)));

  // A pending shadow applies at the period boundary, or immediately while stopped.
  assign apply_c = busy && (wrap_c || !enable);

  // Counter, active/shadow configuration and posedge outputs.
  always_ff @(posedge src_clk) begin
    if (reset) begin
      count    <= '0;
      div_r    <= WIDTH'(DIV_DEFAULT);
      high_r   <= WIDTH'(HIGH_DEFAULT);
      shd_div  <= WIDTH'(DIV_DEFAULT);
      shd_high <= WIDTH'(HIGH_DEFAULT);
      busy     <= 1'b0;
      clk_pos  <= 1'b0;
      tick     <= 1'b0;
      err      <= 1'b0;
    end else begin
      count   <= (!enable || wrap_c) ? '0 : count + WIDTH'(1);
      clk_pos <= enable && (count < high_r);
      tick    <= enable && (count == '0);
      err     <= load && !load_ok_c;

      // The value pending before this edge applies; a same-cycle load refills the shadow.
      if (apply_c) begin
        div_r  <= shd_div;
        high_r <= shd_high;
      end

      if (load && load_ok_c) begin
        shd_div  <= div_ratio;
        shd_high <= high_cnt;
        busy     <= 1'b1;
      end else if (apply_c) begin
        busy <= 1'b0;
      end
    end
  end

`ifdef PROG_CLK_HALF_CYCLE_EN
  logic clk_neg;

  // Half-cycle extension: clk_neg holds clk_pos for an extra half period.
  always_ff @(negedge src_clk) begin
    if (reset) begin
      clk_neg <= 1'b0;
    end else begin
      clk_neg <= clk_pos;
    end
  end

  assign clk_out = clk_pos | (half_en & clk_neg);
`else
  logic unused_half_en;

  assign unused_half_en = half_en;
  assign clk_out        = clk_pos;
`endif

endmodule
